// File: rtl/csa_tree_mul_pipe.sv
// Three-stage pipelined carry-save (Wallace) multiplier with tag, back-pressure and flush.
// Baugh-Wooley partial products; S1 reduces to <=6 rows, S2 to sum/carry, S3 resolves the product.

package csa_tree_mul_pipe_pkg;

    function automatic int unsigned csa_next(input int unsigned n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    function automatic int unsigned csa_rows(input int unsigned n, input int unsigned lvl);
        int unsigned c;
        c = n;
        for (int unsigned l = 0; l < lvl; l++) c = csa_next(c);
        return c;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n, input int unsigned tgt);
        int unsigned c;
        int unsigned l;
        c = n;
        l = 0;
        while (c > tgt && c > 2) begin
            c = csa_next(c);
            l++;
        end
        return l;
    endfunction

endpackage

// One 3:2 level per recursion step until at most TGT rows remain.
module csa_tree_mul_reduce
    import csa_tree_mul_pipe_pkg::*;
#(
    parameter int unsigned P     = 64,
    parameter int unsigned N_IN  = 33,
    parameter int unsigned TGT   = 6,
    parameter int unsigned N_OUT = csa_rows(N_IN, csa_levels(N_IN, TGT))
) (
    input  logic [P-1:0] rows_i [N_IN],
    output logic [P-1:0] rows_o [N_OUT]
);

    if (N_IN <= TGT || N_IN <= 2) begin : g_done
        assign rows_o = rows_i;
    end else begin : g_lvl
        localparam int unsigned NG = N_IN / 3;
        localparam int unsigned NX = csa_next(N_IN);

        logic [P-1:0] nxt [NX];

        for (genvar g = 0; g < NG; g++) begin : g_fa
            logic [P-1:0] maj;
            assign maj = (rows_i[3*g] & rows_i[3*g+1]) |
                         (rows_i[3*g] & rows_i[3*g+2]) |
                         (rows_i[3*g+1] & rows_i[3*g+2]);
            assign nxt[2*g]   = rows_i[3*g] ^ rows_i[3*g+1] ^ rows_i[3*g+2];
            // Carry moves one column up; anything beyond bit P-1 falls off.
            assign nxt[2*g+1] = maj << 1;
        end

        for (genvar p = 0; p < N_IN - 3*NG; p++) begin : g_pass
            assign nxt[2*NG+p] = rows_i[3*NG+p];
        end

        csa_tree_mul_reduce #(
            .P     (P),
            .N_IN  (NX),
            .TGT   (TGT),
            .N_OUT (N_OUT)
        ) u_next (
            .rows_i (nxt),
            .rows_o (rows_o)
        );
    end

endmodule

module csa_tree_mul_pipe
    import csa_tree_mul_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned P  = 2 * WIDTH;
    localparam int unsigned NR = WIDTH + 1;
    localparam int unsigned N1 = csa_rows(NR, csa_levels(NR, 6));
    localparam logic [P-1:0] BW_CORR = (P'(1) << WIDTH) | (P'(1) << (P - 1));

    logic [P-1:0] pp      [NR];
    logic [P-1:0] red1    [N1];
    logic [P-1:0] red2    [2];
    logic [P-1:0] rows1_d [N1];
    logic [P-1:0] rows1_q [N1];

    logic             v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    logic [TAG_W-1:0] tag1_d, tag1_q, tag2_d, tag2_q, tag3_d, tag3_q;
    logic [P-1:0]     sum2_d, sum2_q, car2_d, car2_q, prod3_d, prod3_q;
    logic             adv1, adv2, adv3, acc;

    // Baugh-Wooley rows: MSB term flipped in rows 0..W-2, all but MSB flipped in the last row.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        if (i < WIDTH - 1) begin : g_row
            assign pp[i] = P'({in_signed ^ (in_a[WIDTH-1] & in_b[i]),
                               in_a[WIDTH-2:0] & {(WIDTH-1){in_b[i]}}}) << i;
        end else begin : g_last
            assign pp[i] = P'({in_a[WIDTH-1] & in_b[i],
                               {(WIDTH-1){in_signed}} ^ (in_a[WIDTH-2:0] & {(WIDTH-1){in_b[i]}})}) << i;
        end
    end
    assign pp[WIDTH] = in_signed ? BW_CORR : '0;

    csa_tree_mul_reduce #(
        .P     (P),
        .N_IN  (NR),
        .TGT   (6),
        .N_OUT (N1)
    ) u_s1_tree (
        .rows_i (pp),
        .rows_o (red1)
    );

    csa_tree_mul_reduce #(
        .P     (P),
        .N_IN  (N1),
        .TGT   (2),
        .N_OUT (2)
    ) u_s2_tree (
        .rows_i (rows1_q),
        .rows_o (red2)
    );

    // Stage advance, next-state and data capture; a held stage keeps its contents.
    always_comb begin
        adv3     = !v3_q | out_ready;
        adv2     = !v2_q | adv3;
        adv1     = !v1_q | adv2;
        in_ready = adv1;
        acc      = in_valid & adv1;

        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        tag3_d  = tag3_q;
        rows1_d = rows1_q;
        sum2_d  = sum2_q;
        car2_d  = car2_q;
        prod3_d = prod3_q;

        if (adv1) v1_d = in_valid;
        if (acc) begin
            rows1_d = red1;
            tag1_d  = in_tag;
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                sum2_d = red2[0];
                car2_d = red2[1];
                tag2_d = tag1_q;
            end
        end

        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) begin
                prod3_d = sum2_q + car2_q;
                tag3_d  = tag2_q;
            end
        end

        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            rows1_q <= '{default: '0};
            sum2_q  <= '0;
            car2_q  <= '0;
            prod3_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
            tag3_q  <= tag3_d;
            rows1_q <= rows1_d;
            sum2_q  <= sum2_d;
            car2_q  <= car2_d;
            prod3_q <= prod3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_prod  = prod3_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_csa_tree_mul_pipe.sv
// Scoreboard bench for csa_tree_mul_pipe at WIDTH=32: directed products, back-pressure,
// flush and asynchronous reset; a forked monitor pops expected results on every transfer.
module tb_csa_tree_mul_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_signed;
    logic [TW-1:0]   in_tag;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_prod;
    logic [TW-1:0]   out_tag;

    typedef struct {
        logic [63:0] prod;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];
    int   n_tests;
    int   n_fail;
    logic rand_rdy;

    csa_tree_mul_pipe #(
        .WIDTH (W),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] xa;
        logic signed [63:0] xb;
        xa = {{32{s & a[31]}}, a};
        xb = {{32{s & b[31]}}, b};
        return 64'(xa * xb);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] p);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.p = p;
        vq.push_back(v);
    endtask

    // Compares every completed transfer against the head of the scoreboard.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag %0d prod %h, expected no output", out_tag, out_prod);
                end else begin
                    e = sb.pop_front();
                    chk("out_prod", out_prod, e.prod);
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
                end
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [3:0] tag, input logic [63:0] p);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        for (int k = 0; k < 100 && !acc; k++) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready && !flush && !rst;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.prod = p;
            e.tag  = tag;
            sb.push_back(e);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout tag %0d: got in_ready=0, expected acceptance", tag);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rand_rdy  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_prod", out_prod, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        fork
            monitor();
        join_none

        // Smoke: exact 3-cycle latency
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd3, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        chk("lat_valid_c2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_valid_c3", 64'(out_valid), 64'd1);
        chk("lat_prod", out_prod, 64'hFFFF_FFFE_0000_0001);
        chk("lat_tag", 64'(out_tag), 64'd3);
        drain();

        // Directed products, back-to-back
        add_vec(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        add_vec(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        add_vec(32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000);
        add_vec(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        add_vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);
        add_vec(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);
        add_vec(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
        add_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 64'h0000_0000_8000_0000);
        add_vec(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 64'h0000_0000_8000_0000);
        add_vec(32'h0000_0003, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7);
        add_vec(32'h0000_0003, 32'hFFFF_FFFD, 1'b0, 64'h0000_0002_FFFF_FFF7);
        add_vec(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001);
        add_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF);
        foreach (vq[i]) issue(vq[i].a, vq[i].b, vq[i].s, 4'(i), vq[i].p);
        drain();

        // Back-pressure: three ops fill the pipe, the fourth must wait
        out_ready = 1'b0;
        issue(32'd5, 32'd7, 1'b0, 4'd1, 64'd35);
        issue(32'h10, 32'h10, 1'b0, 4'd2, 64'h100);
        issue(32'hFFFF_FFFF, 32'h2, 1'b0, 4'd3, 64'h1_FFFF_FFFE);
        in_valid  = 1'b1;
        in_a      = 32'h8000_0000;
        in_b      = 32'h8000_0000;
        in_signed = 1'b1;
        in_tag    = 4'd4;
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_tag_held", 64'(out_tag), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_prod_stable", out_prod, 64'd35);
        chk("bp_tag_stable", 64'(out_tag), 64'd1);
        chk("bp_in_ready2", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd4, 64'h4000_0000_0000_0000);
        drain();

        // Flush with three ops in flight and an input offered in the flush cycle
        issue(32'd2, 32'd3, 1'b0, 4'd7, 64'd6);
        issue(32'd4, 32'd5, 1'b0, 4'd8, 64'd20);
        issue(32'd6, 32'd7, 1'b0, 4'd9, 64'd42);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'd9;
        in_b      = 32'd9;
        in_signed = 1'b0;
        in_tag    = 4'd10;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("flush_quiet", 64'(out_valid), 64'd0);
        issue(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 4'd11, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk); #1;
        chk("flush_new_c2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("flush_new_c3", 64'(out_valid), 64'd1);
        drain();

        // Asynchronous reset between edges with two ops in flight
        out_ready = 1'b0;
        issue(32'h0000_0003, 32'hFFFF_FFFD, 1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFF7);
        issue(32'd11, 32'd13, 1'b0, 4'd6, 64'd143);
        @(posedge clk); #1;
        chk("arst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_prod", out_prod, 64'd0);
        chk("arst_out_tag", 64'(out_tag), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_no_result", 64'(out_valid), 64'd0);
        issue(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 4'd12, 64'h0000_0000_FFFE_0001);
        drain();

        // Mixed operands with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, 4'(i), ref_mul(a, b, s));
        end
        rand_rdy = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
